posit_mac_seq: RTL and testbench

Sequencer for one `posit_mac_f_es0` instance (posit, es=0). It turns a START command plus a stream of operand pairs into one complete dot-product job: purge, optional bias load, LEN multiply-accumulates, a pipeline drain, and a single result read. The captured posit result is then held on a valid/ready output port. It sits between the operand-fetch logic and the MAC datapath, and owns every MAC control strobe.

---
 rtl/posit_mac_seq.sv | 150 +++++++++++++++
 tb/tb_posit_mac_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_mac_seq.sv
// Job sequencer for a single posit (es=0) MAC: purge, optional bias load,
// LEN multiply-accumulates, drain, result read and a valid/ready result hold.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for START; cnt and bias flag latched on accept
// CLEAR | PURGE pulse, quire cleared for the new job
// BIAS  | BIAS_EN pulse, bias operand loaded into the empty quire
// RUN   | OP_READY high; each accepted pair issues MAC_EN, cnt-1
// DRAIN | idle cycle so the last product commits to the quire
// READ  | RESULT_REQ_PLS pulse, RES_DATA captured from MAC_OUT
// HOLD  | RES_VALID high until RES_READY
module posit_mac_seq #(
    parameter int N     = 8,
    parameter int LEN_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [LEN_W-1:0] LEN,
    input  logic             USE_BIAS,
    input  logic             ABORT,
    input  logic             OP_VALID,
    output logic             OP_READY,
    input  logic [N-1:0]     OP_IN1,
    input  logic [N-1:0]     OP_IN2,
    output logic [N-1:0]     MAC_IN1,
    output logic [N-1:0]     MAC_IN2,
    output logic             MAC_EN,
    output logic             PURGE,
    output logic             BIAS_EN,
    output logic             RESULT_REQ_PLS,
    input  logic [N-1:0]     MAC_OUT,
    output logic [N-1:0]     RES_DATA,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic             BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_BIAS,
        S_RUN,
        S_DRAIN,
        S_READ,
        S_HOLD
    } state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic             bias_q, bias_nxt;
    logic             cap;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bias_q   <= 1'b0;
            RES_DATA <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            bias_q <= bias_nxt;
            if (cap) begin
                RES_DATA <= MAC_OUT;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        bias_nxt       = bias_q;
        OP_READY       = 1'b0;
        MAC_EN         = 1'b0;
        PURGE          = 1'b0;
        BIAS_EN        = 1'b0;
        RESULT_REQ_PLS = 1'b0;
        cap            = 1'b0;

        case (state)
            S_IDLE: begin
                if (START) begin
                    state_nxt = S_CLEAR;
                    cnt_nxt   = LEN;
                    bias_nxt  = USE_BIAS;
                end
            end
            S_CLEAR: begin
                PURGE = 1'b1;
                if (bias_q) begin
                    state_nxt = S_BIAS;
                end else if (cnt != '0) begin
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_DRAIN;
                end
            end
            S_BIAS: begin
                BIAS_EN   = 1'b1;
                state_nxt = (cnt != '0) ? S_RUN : S_DRAIN;
            end
            S_RUN: begin
                OP_READY = 1'b1;
                if (OP_VALID) begin
                    MAC_EN  = 1'b1;
                    cnt_nxt = cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_nxt = S_READ;
            end
            S_READ: begin
                RESULT_REQ_PLS = 1'b1;
                cap            = 1'b1;
                state_nxt      = S_HOLD;
            end
            S_HOLD: begin
                if (RES_READY) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // abort wins over every transition and silences all other strobes
        if (ABORT && state != S_IDLE) begin
            state_nxt      = S_IDLE;
            cnt_nxt        = cnt;
            OP_READY       = 1'b0;
            MAC_EN         = 1'b0;
            PURGE          = 1'b1;
            BIAS_EN        = 1'b0;
            RESULT_REQ_PLS = 1'b0;
            cap            = 1'b0;
        end
    end

    assign MAC_IN1   = OP_IN1;
    assign MAC_IN2   = OP_IN2;
    assign RES_VALID = (state == S_HOLD);
    assign BUSY      = (state != S_IDLE);

endmodule

// File: tb/tb_posit_mac_seq.sv
// Bench for posit_mac_seq: a behavioural posit8/es0 MAC with a one-cycle product
// stage feeds MAC_OUT; expected results go through a scoreboard queue.
module tb_posit_mac_seq;
    localparam int N     = 8;
    localparam int LEN_W = 8;

    logic             CLK = 1'b0;
    logic             RESET = 1'b0;
    logic             START = 1'b0;
    logic [LEN_W-1:0] LEN = '0;
    logic             USE_BIAS = 1'b0;
    logic             ABORT = 1'b0;
    logic             OP_VALID = 1'b0;
    logic [N-1:0]     OP_IN1 = '0;
    logic [N-1:0]     OP_IN2 = '0;
    logic             RES_READY = 1'b0;
    logic             OP_READY, MAC_EN, PURGE, BIAS_EN, RESULT_REQ_PLS, RES_VALID, BUSY;
    logic [N-1:0]     MAC_IN1, MAC_IN2, MAC_OUT, RES_DATA;

    posit_mac_seq #(.N(N), .LEN_W(LEN_W)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .LEN(LEN), .USE_BIAS(USE_BIAS),
        .ABORT(ABORT), .OP_VALID(OP_VALID), .OP_READY(OP_READY),
        .OP_IN1(OP_IN1), .OP_IN2(OP_IN2), .MAC_IN1(MAC_IN1), .MAC_IN2(MAC_IN2),
        .MAC_EN(MAC_EN), .PURGE(PURGE), .BIAS_EN(BIAS_EN),
        .RESULT_REQ_PLS(RESULT_REQ_PLS), .MAC_OUT(MAC_OUT), .RES_DATA(RES_DATA),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pa[8];
    logic [7:0] pb[8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic real p2r(input logic [7:0] p);
        logic [7:0] m;
        logic       r;
        real        v, sc;
        int         i, run, k;
        if (p == 8'h00 || p == 8'h80) return 0.0;
        m   = p[7] ? -p : p;
        r   = m[6];
        run = 0;
        i   = 6;
        while (i >= 0 && m[i] == r) begin
            run++;
            i--;
        end
        i--;
        k  = r ? run - 1 : -run;
        v  = 1.0;
        sc = 0.5;
        while (i >= 0) begin
            if (m[i]) v = v + sc;
            sc = sc / 2.0;
            i--;
        end
        for (int j = 0; j < k; j++) v = v * 2.0;
        for (int j = 0; j > k; j--) v = v / 2.0;
        return p[7] ? -v : v;
    endfunction

    function automatic logic [7:0] r2p(input real x);
        logic [7:0] best;
        real        bd, d;
        best = 8'h00;
        bd   = (x < 0.0) ? -x : x;
        for (int i = 1; i < 256; i++) begin
            if (i != 128) begin
                d = p2r(8'(i)) - x;
                if (d < 0.0) d = -d;
                if (d < bd) begin
                    bd   = d;
                    best = 8'(i);
                end
            end
        end
        return best;
    endfunction

    // MAC model: product registered on MAC_EN, added to the quire one cycle later
    real  quire, prod;
    logic prod_v;
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            quire  <= 0.0;
            prod   <= 0.0;
            prod_v <= 1'b0;
        end else if (PURGE) begin
            quire  <= 0.0;
            prod_v <= 1'b0;
        end else begin
            if (prod_v) quire <= quire + prod;
            if (BIAS_EN) quire <= p2r(MAC_IN1);
            prod_v <= MAC_EN;
            if (MAC_EN) prod <= p2r(MAC_IN1) * p2r(MAC_IN2);
        end
    end
    always_comb MAC_OUT = r2p(quire);

    task automatic run_job(input int len, input bit ub, input logic [7:0] bias,
                           input int stall_n, input int abort_cyc, input int hold_n,
                           input logic [7:0] exp_res);
        int c, idx, stalls, hold_left;
        int first_en, last_en, n_en, n_purge, purge_c, n_bias, bias_c, rreq_c, rv_c;
        bit done, stalling;
        logic [7:0] held, e;
        if (abort_cyc < 0) exp_q.push_back(exp_res);
        START    = 1'b1;
        LEN      = LEN_W'(len);
        USE_BIAS = ub;
        @(negedge CLK);
        chk("idle_at_start", BUSY, 0);
        @(posedge CLK);
        #1;
        START = 1'b0;
        c = 1; idx = 0; stalls = 0; hold_left = 0; done = 0;
        first_en = -1; last_en = -1; n_en = 0; n_purge = 0; purge_c = -1;
        n_bias = 0; bias_c = -1; rreq_c = -1; rv_c = -1; held = '0;
        while (!done && c < 60) begin
            ABORT    = (c == abort_cyc);
            stalling = 1'b0;
            if (ub && c <= 2) begin
                OP_VALID = 1'b0;
                OP_IN1   = bias;
                OP_IN2   = 8'h00;
            end else if (idx < len) begin
                OP_IN1   = pa[idx];
                OP_IN2   = pb[idx];
                stalling = (idx == 1 && stalls < stall_n);
                OP_VALID = !stalling;
            end else begin
                OP_VALID = 1'b0;
                OP_IN1   = 8'h00;
                OP_IN2   = 8'h00;
            end
            if (rv_c >= 0) begin
                RES_READY = (hold_left == 0);
                START     = (hold_left > 0);
            end
            @(negedge CLK);
            if (c == 1) chk("mac_in_copy", {MAC_IN1, MAC_IN2}, {OP_IN1, OP_IN2});
            if (MAC_EN) begin
                n_en++;
                if (first_en < 0) first_en = c;
                last_en = c;
            end
            if (PURGE) begin
                n_purge++;
                if (purge_c < 0) purge_c = c;
            end
            if (BIAS_EN) begin
                n_bias++;
                bias_c = c;
            end
            if (RESULT_REQ_PLS && rreq_c < 0) rreq_c = c;
            if (stalling) begin
                chk("stall_op_ready", OP_READY, 1);
                stalls++;
            end
            if (c == abort_cyc) begin
                chk("abort_strobes", {PURGE, MAC_EN, OP_READY, BIAS_EN, RESULT_REQ_PLS}, 5'b10000);
                done = 1;
            end else if (OP_VALID && OP_READY) begin
                idx++;
            end
            if (!done && rv_c >= 0) begin
                if (RES_READY) begin
                    chk("handshake_valid", RES_VALID, 1);
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_empty", 0, 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_data", RES_DATA, e);
                    end
                    done = 1;
                end else begin
                    chk("hold_stable", {RES_VALID, RES_DATA}, {1'b1, held});
                    hold_left--;
                end
            end else if (!done && RES_VALID) begin
                rv_c      = c;
                held      = RES_DATA;
                hold_left = hold_n;
            end
            if (!done) begin
                @(posedge CLK);
                #1;
                c++;
            end
        end
        @(posedge CLK);
        #1;
        START = 1'b0; RES_READY = 1'b0; OP_VALID = 1'b0; ABORT = 1'b0;
        if (!done) chk("job_timeout", 0, 1);
        chk("idle_after_job", BUSY, 0);
        if (abort_cyc >= 0) begin
            chk("abort_mac_en_count", n_en, abort_cyc - 2);
            repeat (3) @(posedge CLK);
            #1;
            chk("abort_no_valid", RES_VALID, 0);
        end else begin
            chk("purge_count", n_purge, 1);
            chk("purge_cycle", purge_c, 1);
            chk("mac_en_count", n_en, len);
            if (len > 0) begin
                chk("first_mac_en", first_en, 2 + int'(ub));
                chk("last_mac_en", last_en, len + 1 + int'(ub) + stall_n);
            end
            chk("bias_en_count", n_bias, int'(ub));
            if (ub) chk("bias_en_cycle", bias_c, 2);
            chk("req_cycle", rreq_c, len + 3 + int'(ub) + stall_n);
            chk("valid_cycle", rv_c, len + 4 + int'(ub) + stall_n);
        end
    endtask

    initial begin
        #12;
        chk("reset_outputs", {BUSY, RES_VALID, OP_READY, MAC_EN, PURGE, BIAS_EN, RESULT_REQ_PLS}, 7'b0);
        chk("reset_res_data", RES_DATA, 8'h00);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        // 3 x (1.0 * 1.0) = 3.0
        for (int i = 0; i < 3; i++) begin pa[i] = 8'h40; pb[i] = 8'h40; end
        run_job(3, 1'b0, 8'h00, 0, -1, 0, 8'h68);

        // 1.0 + 2.0*0.5 + (-1.0)*1.0 = 1.0
        pa[0] = 8'h60; pb[0] = 8'h20; pa[1] = 8'hC0; pb[1] = 8'h40;
        run_job(2, 1'b1, 8'h40, 0, -1, 0, 8'h40);

        // 2 x (1.0 * 1.0) with a 3-cycle stall between pairs
        pa[0] = 8'h40; pb[0] = 8'h40; pa[1] = 8'h40; pb[1] = 8'h40;
        run_job(2, 1'b0, 8'h00, 3, -1, 0, 8'h60);

        // empty job, consumer stalls 5 cycles while START is held high
        run_job(0, 1'b0, 8'h00, 0, -1, 5, 8'h00);

        // abort in the second RUN cycle, then a fresh job
        for (int i = 0; i < 4; i++) begin pa[i] = 8'h40; pb[i] = 8'h40; end
        run_job(4, 1'b0, 8'h00, 0, 3, 0, 8'h00);
        run_job(1, 1'b0, 8'h00, 0, -1, 0, 8'h40);

        // reset pulsed in DRAIN of a LEN=1 job
        START = 1'b1; LEN = 8'd1; USE_BIAS = 1'b0;
        OP_VALID = 1'b1; OP_IN1 = 8'h40; OP_IN2 = 8'h40;
        @(posedge CLK); #1; START = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1; OP_VALID = 1'b0;
        #2;
        chk("pre_reset_busy", BUSY, 1);
        RESET = 1'b0;
        #1;
        chk("async_reset_outputs", {BUSY, RES_VALID, OP_READY, MAC_EN, PURGE, BIAS_EN, RESULT_REQ_PLS}, 7'b0);
        chk("async_reset_res_data", RES_DATA, 8'h00);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        pa[0] = 8'h60; pb[0] = 8'h60;
        run_job(1, 1'b0, 8'h00, 0, -1, 0, 8'h70);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "global timeout");
    end
endmodule
